// File: rtl/comparator_seq.sv
// ---------------------------------------------------------------------------
// comparator_seq
//   Sequential multi-mode comparator. Two WIDTH-bit operands are compared
//   SLICE bits per clock, starting at the most significant slice. The
//   compare stops at the first slice that differs. This replaces one deep
//   combinational XOR/NOR tree with a short per-slice compare.
//
// Parameters
//   WIDTH  operand width in bits (must be a multiple of SLICE)
//   SLICE  bits compared per clock
//
// Ports
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   start   in   request, accepted in IDLE or DONE
//   a, b    in   operands, latched on the accepting edge
//   mode    in   0 EQ, 1 NE, 2 LTU, 3 GTU, 4 LEU, 5 GEU, 6 LTS, 7 GTS
//   busy    out  high while a compare is running
//   done    out  one-cycle pulse, result valid
//   result  out  boolean outcome of the latched mode
//   eq      out  A == B
//   lt      out  A <  B (signed for signed modes)
//   gt      out  A >  B (signed for signed modes)
// ---------------------------------------------------------------------------
module comparator_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       mode,
    output logic             busy,
    output logic             done,
    output logic             result,
    output logic             eq,
    output logic             lt,
    output logic             gt
);

    localparam int NS    = WIDTH / SLICE;
    localparam int IDX_W = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [WIDTH-1:0] SIGN_MASK = WIDTH'(1) << (WIDTH - 1);

    generate
        if ((WIDTH % SLICE) != 0) begin : g_bad_cfg
            $error("comparator_seq: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_mode;
    logic [IDX_W-1:0] r_idx;
    logic             r_eq;
    logic             r_lt;
    logic             r_gt;
    logic             r_result;

    logic [SLICE-1:0] w_sa;
    logic [SLICE-1:0] w_sb;
    logic             w_accept;
    logic             w_slice_ne;
    logic             w_finish;
    logic             w_eq_n;
    logic             w_lt_n;
    logic             w_gt_n;

    // Flipping the sign bit maps two's-complement order onto unsigned order,
    // so signed modes reuse the unsigned slice compare unchanged.
    function automatic logic [WIDTH-1:0] f_capture(input logic [WIDTH-1:0] op,
                                                   input logic             is_signed);
        return is_signed ? (op ^ SIGN_MASK) : op;
    endfunction

    function automatic logic f_map(input logic [2:0] m,
                                   input logic       e,
                                   input logic       l,
                                   input logic       g);
        logic res;
        case (m)
            3'd0:    res = e;
            3'd1:    res = !e;
            3'd2:    res = l;
            3'd3:    res = g;
            3'd4:    res = l | e;
            3'd5:    res = g | e;
            3'd6:    res = l;
            default: res = g;
        endcase
        return res;
    endfunction

    assign w_sa       = r_a[int'(r_idx) * SLICE +: SLICE];
    assign w_sb       = r_b[int'(r_idx) * SLICE +: SLICE];
    assign w_slice_ne = (w_sa != w_sb);
    assign w_finish   = w_slice_ne || (r_idx == '0);
    assign w_eq_n     = !w_slice_ne;
    assign w_lt_n     = w_slice_ne && (w_sa < w_sb);
    assign w_gt_n     = w_slice_ne && (w_sa > w_sb);
    // DONE accepts too, which gives back-to-back compares with no idle bubble.
    assign w_accept   = start && (r_state != S_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_finish) w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = w_accept ? S_RUN : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_mode   <= '0;
            r_idx    <= '0;
            r_eq     <= 1'b0;
            r_lt     <= 1'b0;
            r_gt     <= 1'b0;
            r_result <= 1'b0;
        end else if (w_accept) begin
            r_a    <= f_capture(a, mode[2] & mode[1]);
            r_b    <= f_capture(b, mode[2] & mode[1]);
            r_mode <= mode;
            r_idx  <= IDX_W'(NS - 1);
        end else if (r_state == S_RUN) begin
            if (w_finish) begin
                r_eq     <= w_eq_n;
                r_lt     <= w_lt_n;
                r_gt     <= w_gt_n;
                r_result <= f_map(r_mode, w_eq_n, w_lt_n, w_gt_n);
            end else begin
                r_idx <= r_idx - IDX_W'(1);
            end
        end
    end

    assign result = r_result;
    assign eq     = r_eq;
    assign lt     = r_lt;
    assign gt     = r_gt;

endmodule

// File: doc/comparator_seq.md
Name: comparator_seq

Overview:
- Parametrised, multi-mode, sequential successor to the fixed 8-bit equality comparator.
- Compares two WIDTH-bit operands SLICE bits per cycle, starting at the MSB slice.
- Terminates early at the first differing slice.
- Start/busy/done handshake, so wide compares avoid one deep combinational XOR/NOR tree in arithmetic datapaths.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of SLICE.
- SLICE, 8, bits compared per cycle; NS = WIDTH/SLICE slices.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; accepted when state is IDLE or DONE.
- a  input  WIDTH  operand A; sampled only on the accepting edge.
- b  input  WIDTH  operand B; sampled only on the accepting edge.
- mode  input  3  compare mode, sampled with the operands: 0 EQ, 1 NE, 2 LTU, 3 GTU, 4 LEU, 5 GEU, 6 LTS, 7 GTS.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result is valid.
- result  output  1  boolean outcome of the selected mode.
- eq  output  1  A == B.
- lt  output  1  A < B (signed when the mode is signed).
- gt  output  1  A > B (signed when the mode is signed).

Behaviour:
- Reset: when rst_n is low, state=IDLE, busy=0, done=0, result=0, eq=0, lt=0, gt=0, all internal registers cleared. Takes effect immediately, clock not required.
- Reset mid-RUN aborts the compare. No done is produced. Operands are discarded.
- States:
  - IDLE: wait for start.
  - RUN: compare one slice per cycle.
  - DONE: 1 cycle, done=1, then IDLE.
- Accept:
  - On an edge with start=1 in IDLE or DONE: latch a, b, mode; set idx=NS-1; next state RUN.
  - start=1 during RUN is ignored. No queueing, no effect on the compare in progress.
- Signed modes (6, 7): bit WIDTH-1 of both latched operands is inverted at capture. All comparison is then unsigned.
- RUN, each edge: compare slice idx, bits [idx*SLICE+SLICE-1 : idx*SLICE] of A vs B.
  - Slice unequal: set lt/gt from the slice magnitude, eq=0, next state DONE.
  - Slice equal and idx==0: eq=1, lt=0, gt=0, next state DONE.
  - Otherwise: idx decrements, stay in RUN.
- Latency:
  - Let k = 1 + (NS-1 - index of the first differing slice from the top), or k = NS if A == B.
  - done is high during the cycle after the k-th edge following the accepting edge.
  - Minimum k = 1, maximum k = NS.
- Result mapping:
  - EQ=eq, NE=!eq.
  - LTU/LTS=lt, GTU/GTS=gt.
  - LEU=lt|eq, GEU=gt|eq.
- Hold and update:
  - eq, lt, gt and result update only on entry to DONE.
  - They hold their values through IDLE and the next RUN until the next DONE.
  - Exactly one of eq/lt/gt is high after the first completed compare.
- Back-to-back: start=1 while done=1 is accepted. The next RUN begins on the following cycle, so there is no idle bubble.
- SLICE==WIDTH: every compare has k=1.
- WIDTH not a multiple of SLICE: elaboration-time error.

Test Plan:
- Reset: rst_n=0 with start=1 and random a/b → busy=0, done=0, eq=lt=gt=result=0. Pulse rst_n low during RUN of a 32-bit equal compare → done never asserts, state IDLE.
- Equal, WIDTH=32, SLICE=8, mode=0, a=b=0xDEADBEEF → busy for 4 cycles, done after the 4th edge, eq=1, result=1.
- Early termination, mode=2, a=0x10000000, b=0x20000000 → done after the 1st edge, lt=1, result=1. Same with a=0x12345600, b=0x12345601 → done after the 4th edge, lt=1.
- Signed vs unsigned, a=0xFFFFFFFF, b=0x00000001:
  - mode=6 (LTS) → lt=1, result=1.
  - mode=3 (GTU) → gt=1, result=1.
  - mode=7 (GTS) → result=0.
- Handshake: start re-asserted during RUN with different operands → ignored, first result intact. start held high through done → second compare begins the next cycle with new operands, done pulses again.
- Parameter sweep: WIDTH=8/SLICE=8, WIDTH=16/SLICE=4, WIDTH=64/SLICE=16 with random operands and all 8 modes → result, eq, lt, gt match the reference model and k matches the latency formula.
